serial_rx_fifo: RTL and testbench
=================================

# serial_rx_fifo

Buffered receive end of the single-wire serial link driven by the codebase's `transmitter` (idle low, start bit high).
- Samples `S_Data` on `Clk_S`, deframes 55-bit words and checks the stop bit.
- Queues good words in a small FIFO and presents them to the router core with a valid/ready handshake.
- Intended as the drop-in router-side receiver where the core cannot always accept a word the moment it arrives.

## Interface
- `DATA_W`, 55: payload bits per frame.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

Ports:
- `Clk_S`  in  1  serial/system clock; all state updates on rising edge.
- `Rst`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `S_Data`  in  1  serial line; idle 0.
- `RX_Ready`  in  1  consumer accepts head word this cycle.
- `RX_Data_Valid`  out  1  FIFO non-empty; `RX_Data` is valid.
- `RX_Data`  out  DATA_W  FIFO head word.
- `Frame_Err`  out  1  one-cycle pulse: bad stop bit, frame dropped.
- `Overflow`  out  1  one-cycle pulse: good frame dropped, FIFO full.

## Operation
- Frame on the line is 1 start bit (1), then `DATA_W` data bits LSB first, then 1 stop bit (0). Total `DATA_W`+2 bit-cycles, one bit per clock.
- FSM states: IDLE, DATA, STOP.
  - IDLE: `S_Data`=1 → DATA, with bit counter cleared. `S_Data`=0 → stay.
  - DATA: shift `S_Data` into `shreg[cnt]`, then increment `cnt`. At `cnt`=`DATA_W`-1 → STOP.
  - STOP: `S_Data`=0 → push `shreg`, then IDLE. `S_Data`=1 → pulse `Frame_Err`, discard, then IDLE. The 1 is not reinterpreted as a start bit.
- Bit counter width is ceil(log2(`DATA_W`)); it never exceeds `DATA_W`-1.
- FIFO:
  - Circular buffer with read/write pointers of log2(`DEPTH`) bits, wrapping modulo `DEPTH`.
  - Occupancy count of log2(`DEPTH`)+1 bits.
  - `RX_Data_Valid` = (count≠0). `RX_Data` = mem[rd_ptr], combinational from registers.
  - Pop occurs when `RX_Data_Valid` & `RX_Ready`. `RX_Ready` while empty is ignored.
- Push with FIFO full and no pop the same cycle: word dropped, `Overflow` pulses, pointers unchanged.
- Push and pop in the same cycle: both occur and count is unchanged. This holds when full, so no overflow. When empty there is no pop, so it is a plain push.
- `Frame_Err` and `Overflow` are mutually exclusive by construction.
- Reset (any time, including mid-frame): FSM→IDLE, `cnt`=0, pointers=0, count=0, partial frame discarded.
  - Reset values: `RX_Data_Valid`=0, `Frame_Err`=0, `Overflow`=0, `RX_Data`=0 (`shreg` and memory cleared).
  - The first frame after reset release needs a fresh start bit.

## Timing
- Let edge E0 be the edge at which IDLE samples the start bit.
  - Data bit i is sampled at edge E0+1+i.
  - The stop bit is sampled at E0+`DATA_W`+1 (E0+56 by default).
- Push lands at the stop-bit edge. With the FIFO empty before that edge, `RX_Data_Valid` is 1 immediately after it, with `RX_Data` = word.
  - Latency from start-bit edge to valid: `DATA_W`+1 edges.
- `Frame_Err` and `Overflow` are registered, high for exactly the one cycle following the stop-bit edge.
- Back-to-back frames: a start bit may appear on the cycle right after the stop bit. IDLE catches it with no gap cycle.
- Pop takes effect at the edge where valid & ready are sampled high. The next head (or valid=0) is visible after that edge, so zero-bubble streaming works with `RX_Ready` held high.
- Sustained rate is one word per `DATA_W`+2 cycles, so the FIFO only fills when `RX_Ready` is held low.

## Test plan
- Reset: assert `Rst` mid-idle, check outputs immediately (async, no clock edge needed) → `RX_Data_Valid`=0, `Frame_Err`=0, `Overflow`=0, `RX_Data`=0.
- Single frame: release reset, send payload 55'h3 with `RX_Ready`=0.
  - `RX_Data_Valid` rises 56 edges after the start edge, `RX_Data`=55'h3.
  - Raise `RX_Ready` for 1 cycle → valid drops.
- Framing error: send payload 55'h7FFF_FFFF_FFFF_FF with stop bit 1.
  - `Frame_Err` pulses exactly 1 cycle; `RX_Data_Valid` stays 0.
  - A following good frame 55'h1 is received correctly.
- Fill and overflow: `RX_Ready`=0, send 5 back-to-back frames 1..5.
  - After frame 4, valid=1 and count=4. Frame 5 → `Overflow` pulse.
  - Draining yields exactly 1,2,3,4 in order; the pointers wrap correctly on a second fill.
- Push/pop when full: FIFO holds 1..4, and the stop edge of frame 5 coincides with `RX_Ready`=1.
  - No `Overflow`; the drain sequence is 2,3,4,5.
- Reset mid-frame: assert `Rst` after 20 data bits of a frame, with 2 words queued.
  - FIFO empties; the rest of the bits are ignored until a new start bit.
  - The next frame, 55'h55_5555_5555_5555, is received intact.

Source files
------------

// File: rtl/serial_rx_fifo.sv
// Receive end of the single-wire serial link: deframes start/data/stop frames
// and queues good words in a small FIFO drained through a valid/ready handshake.
module serial_rx_fifo #(
    parameter int DATA_W = 55,
    parameter int DEPTH  = 4
) (
    input  logic              Clk_S,
    input  logic              Rst,
    input  logic              S_Data,
    input  logic              RX_Ready,
    output logic              RX_Data_Valid,
    output logic [DATA_W-1:0] RX_Data,
    output logic              Frame_Err,
    output logic              Overflow
);

    localparam int CNT_W  = $clog2(DATA_W);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              ferr_q, ferr_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic push_req;
    logic pop;
    logic full;
    logic do_push;

    // Deframer. Handshake on the consumer side: a word transfers at every
    // rising edge where RX_Data_Valid and RX_Ready are both high.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        ferr_d   = 1'b0;
        push_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (S_Data) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                shreg_d[cnt_q] = S_Data;
                if (cnt_q == LAST_BIT) begin
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                // A high stop bit is consumed here, never taken as the next start bit.
                if (S_Data) begin
                    ferr_d = 1'b1;
                end else begin
                    push_req = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign full    = (occ_q == FULL_OCC);
    assign pop     = (occ_q != '0) && RX_Ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the word.
    assign do_push = push_req && (!full || pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        ovf_d    = push_req && full && !pop;
        if (do_push) begin
            mem_d[wr_ptr_q] = shreg_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !do_push) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge Clk_S or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            ferr_q   <= ferr_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign RX_Data_Valid = (occ_q != '0);
    assign RX_Data       = mem_q[rd_ptr_q];
    assign Frame_Err     = ferr_q;
    assign Overflow      = ovf_q;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed bench for serial_rx_fifo: drives frames bit by bit and checks the
// FIFO head, handshake and error pulses against a queue of expected words.
module tb_serial_rx_fifo;

    localparam int DATA_W = 55;
    localparam int DEPTH  = 4;

    logic              Clk_S = 1'b0;
    logic              Rst;
    logic              S_Data;
    logic              RX_Ready;
    logic              RX_Data_Valid;
    logic [DATA_W-1:0] RX_Data;
    logic              Frame_Err;
    logic              Overflow;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    serial_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .Clk_S        (Clk_S),
        .Rst          (Rst),
        .S_Data       (S_Data),
        .RX_Ready     (RX_Ready),
        .RX_Data_Valid(RX_Data_Valid),
        .RX_Data      (RX_Data),
        .Frame_Err    (Frame_Err),
        .Overflow     (Overflow)
    );

    always #5 Clk_S = ~Clk_S;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge Clk_S);
        #1;
    endtask

    task automatic send_head(input logic [DATA_W-1:0] p);
        S_Data = 1'b1;
        tick();
        for (int i = 0; i < DATA_W; i++) begin
            S_Data = p[i];
            tick();
        end
    endtask

    task automatic send_stop(input logic b);
        S_Data = b;
        tick();
        S_Data = 1'b0;
    endtask

    // Good frame with nothing popping: the model keeps it only if there was room.
    task automatic send_good(input logic [DATA_W-1:0] p);
        send_head(p);
        send_stop(1'b0);
        if (exp_q.size() < DEPTH) exp_q.push_back(p);
    endtask

    task automatic pop_check(input string tag);
        logic [DATA_W-1:0] e;
        e = (exp_q.size() != 0) ? exp_q[0] : '0;
        check({tag, "_valid"}, 64'(RX_Data_Valid), 64'(1));
        check({tag, "_data"}, 64'(RX_Data), 64'(e));
        RX_Ready = 1'b1;
        tick();
        RX_Ready = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic drain_all(input string tag);
        while (exp_q.size() != 0) pop_check(tag);
        check({tag, "_empty"}, 64'(RX_Data_Valid), 64'(0));
    endtask

    initial begin
        Rst      = 1'b0;
        S_Data   = 1'b0;
        RX_Ready = 1'b0;
        tick();
        tick();

        // Asynchronous reset while idle: outputs clear without a clock edge.
        Rst = 1'b1;
        #1;
        check("rst_valid", 64'(RX_Data_Valid), 64'(0));
        check("rst_ferr", 64'(Frame_Err), 64'(0));
        check("rst_ovf", 64'(Overflow), 64'(0));
        check("rst_data", 64'(RX_Data), 64'(0));
        tick();
        Rst = 1'b0;
        exp_q.delete();
        tick();
        tick();

        // Single frame 55'h3: valid appears exactly at the stop-bit edge.
        send_head(55'h3);
        check("single_prestop_valid", 64'(RX_Data_Valid), 64'(0));
        send_stop(1'b0);
        exp_q.push_back(55'h3);
        check("single_valid", 64'(RX_Data_Valid), 64'(1));
        check("single_data", 64'(RX_Data), 64'h3);
        check("single_ferr", 64'(Frame_Err), 64'(0));
        tick();
        check("single_hold_valid", 64'(RX_Data_Valid), 64'(1));
        pop_check("single_pop");
        check("single_after_pop", 64'(RX_Data_Valid), 64'(0));

        // Framing error: all-ones payload with a high stop bit.
        send_head(55'h7FFF_FFFF_FFFF_FF);
        send_stop(1'b1);
        check("ferr_pulse", 64'(Frame_Err), 64'(1));
        check("ferr_valid", 64'(RX_Data_Valid), 64'(0));
        check("ferr_ovf", 64'(Overflow), 64'(0));
        tick();
        check("ferr_one_cycle", 64'(Frame_Err), 64'(0));
        check("ferr_still_empty", 64'(RX_Data_Valid), 64'(0));
        send_good(55'h1);
        check("ferr_next_ferr", 64'(Frame_Err), 64'(0));
        drain_all("ferr_next");

        // Fill with back-to-back frames, then overflow on the fifth.
        send_good(55'd1);
        send_good(55'd2);
        send_good(55'd3);
        send_good(55'd4);
        check("fill_valid", 64'(RX_Data_Valid), 64'(1));
        check("fill_head", 64'(RX_Data), 64'd1);
        check("fill_no_ovf", 64'(Overflow), 64'(0));
        send_good(55'd5);
        check("ovf_pulse", 64'(Overflow), 64'(1));
        check("ovf_ferr", 64'(Frame_Err), 64'(0));
        tick();
        check("ovf_one_cycle", 64'(Overflow), 64'(0));
        drain_all("drain1");

        // Second fill with pointers wrapping past the end of the buffer.
        send_good(55'd6);
        send_good(55'd7);
        pop_check("wrap_pop");
        send_good(55'd8);
        send_good(55'd9);
        send_good(55'd10);
        check("wrap_full_no_ovf", 64'(Overflow), 64'(0));
        drain_all("wrap");

        // Full FIFO with a pop at the same edge as the fifth stop bit.
        send_good(55'd1);
        send_good(55'd2);
        send_good(55'd3);
        send_good(55'd4);
        send_head(55'd5);
        RX_Ready = 1'b1;
        send_stop(1'b0);
        RX_Ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(55'd5);
        check("pushpop_no_ovf", 64'(Overflow), 64'(0));
        check("pushpop_head", 64'(RX_Data), 64'd2);
        drain_all("pushpop");

        // Reset in the middle of a frame with two words queued.
        send_good(55'hA);
        send_good(55'hB);
        S_Data = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            S_Data = 1'b1;
            tick();
        end
        Rst = 1'b1;
        #1;
        check("midrst_valid", 64'(RX_Data_Valid), 64'(0));
        check("midrst_data", 64'(RX_Data), 64'(0));
        exp_q.delete();
        S_Data = 1'b0;
        tick();
        Rst = 1'b0;
        for (int i = 21; i < DATA_W + 1; i++) begin
            S_Data = 1'b0;
            tick();
        end
        tick();
        check("midrst_tail_ignored", 64'(RX_Data_Valid), 64'(0));
        check("midrst_tail_ferr", 64'(Frame_Err), 64'(0));
        send_good(55'h55_5555_5555_5555);
        check("midrst_next_valid", 64'(RX_Data_Valid), 64'(1));
        drain_all("midrst_next");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
